// File: rtl/uart_rx_deser_frame.sv
// UART receive deserializer/deframer.
// Consumes a validated start pulse plus one strobe per sampled bit, counts the
// bits itself, assembles DATA_W data bits in either order, checks optional
// parity and one or two stop bits, and holds each frame in a valid/ready
// output register together with its parity and framing flags.
//
// Output handshake: m_valid stays high, with m_data/par_err/frm_err frozen,
// until a cycle where m_valid && m_ready; that cycle consumes the frame. A
// frame completing while an unconsumed frame is held (and not being consumed
// in that same cycle) is dropped and overrun pulses for one cycle.
module uart_rx_deser_frame #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 0,
  parameter int PAR_EN    = 1,
  parameter int PAR_ODD   = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_ok,
  input  logic              sampled_bit,
  input  logic              smpl_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              overrun,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic PAR_ODD_B = (PAR_ODD != 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  shreg_q;
  logic               acc_q;
  logic               par_frame_q;
  logic               stop_err_q;

  // control strobes decoded from the current state
  logic frame_start;
  logic data_shift;
  logic par_sample;
  logic stop_sample;
  logic commit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start_ok only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_DATA;
      S_DATA:   if (smpl_ready && cnt_q == DATA_LAST)
                  state_d = (PAR_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (smpl_ready) state_d = S_STOP;
      S_STOP:   if (smpl_ready && cnt_q == STOP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: which datapath action the current state performs
  always_comb begin
    frame_start = 1'b0;
    data_shift  = 1'b0;
    par_sample  = 1'b0;
    stop_sample = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE:   frame_start = start_ok;
      S_DATA:   data_shift  = smpl_ready;
      S_PARITY: par_sample  = smpl_ready;
      S_STOP: begin
        stop_sample = smpl_ready;
        commit      = smpl_ready && (cnt_q == STOP_LAST);
      end
      default: ;
    endcase
  end

  // Bit counter, cleared whenever the FSM enters a new state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (state_d != state_q)      cnt_q <= '0;
    else if (data_shift || stop_sample) cnt_q <= cnt_q + 1'b1;
  end

  // Shift register, parity accumulator and per-frame error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q     <= '0;
      acc_q       <= 1'b0;
      par_frame_q <= 1'b0;
      stop_err_q  <= 1'b0;
    end else begin
      if (frame_start) begin
        shreg_q     <= '0;
        acc_q       <= 1'b0;
        par_frame_q <= 1'b0;
        stop_err_q  <= 1'b0;
      end
      if (data_shift) begin
        if (MSB_FIRST != 0) shreg_q <= {shreg_q[DATA_W-2:0], sampled_bit};
        else                shreg_q <= {sampled_bit, shreg_q[DATA_W-1:1]};
        acc_q <= acc_q ^ sampled_bit;
      end
      if (par_sample)
        par_frame_q <= ((acc_q ^ sampled_bit) != PAR_ODD_B);
      if (stop_sample && !sampled_bit)
        stop_err_q <= 1'b1;
    end
  end

  // Output register: load on commit when free or being drained, else flag overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!m_valid || m_ready) begin
          m_data  <= shreg_q;
          par_err <= par_frame_q;
          frm_err <= stop_err_q | ~sampled_bit;
          m_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_deser_frame.sv
// Bench for uart_rx_deser_frame: three instances (8E1, 8O2, 7-bit MSB-first
// no parity) driven bit by bit from frames described as data words; a queue
// per instance holds the frame the output register should be presenting.
module tb_uart_rx_deser_frame;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // per-instance drive signals: 0 = 8E1, 1 = 8O2, 2 = 7N1 MSB-first
  logic [2:0] start_ok    = '0;
  logic [2:0] sampled_bit = '0;
  logic [2:0] smpl_ready  = '0;
  logic [2:0] m_ready     = '0;

  logic [7:0] a_data, b_data;
  logic [6:0] c_data;
  logic [2:0] valid_o, perr_o, ferr_o, ovr_o, busy_o;
  logic [1:0] a_st, b_st, c_st;

  int dw_c   [3] = '{8, 8, 7};
  int msb_c  [3] = '{0, 0, 1};
  int pen_c  [3] = '{1, 1, 0};
  int podd_c [3] = '{0, 1, 0};
  int sb_c   [3] = '{1, 2, 1};

  // expected contents of each output register: {par_err, frm_err, data[8:0]}
  logic [10:0] exp_q [3][$];

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_deser_frame u_a (
    .clk(clk), .rst(rst), .start_ok(start_ok[0]), .sampled_bit(sampled_bit[0]),
    .smpl_ready(smpl_ready[0]), .m_data(a_data), .m_valid(valid_o[0]),
    .m_ready(m_ready[0]), .par_err(perr_o[0]), .frm_err(ferr_o[0]),
    .overrun(ovr_o[0]), .busy(busy_o[0]), .state_dbg(a_st)
  );

  uart_rx_deser_frame #(.PAR_ODD(1), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .start_ok(start_ok[1]), .sampled_bit(sampled_bit[1]),
    .smpl_ready(smpl_ready[1]), .m_data(b_data), .m_valid(valid_o[1]),
    .m_ready(m_ready[1]), .par_err(perr_o[1]), .frm_err(ferr_o[1]),
    .overrun(ovr_o[1]), .busy(busy_o[1]), .state_dbg(b_st)
  );

  uart_rx_deser_frame #(.DATA_W(7), .MSB_FIRST(1), .PAR_EN(0)) u_c (
    .clk(clk), .rst(rst), .start_ok(start_ok[2]), .sampled_bit(sampled_bit[2]),
    .smpl_ready(smpl_ready[2]), .m_data(c_data), .m_valid(valid_o[2]),
    .m_ready(m_ready[2]), .par_err(perr_o[2]), .frm_err(ferr_o[2]),
    .overrun(ovr_o[2]), .busy(busy_o[2]), .state_dbg(c_st)
  );

  function automatic logic [8:0] data_of(input int u);
    case (u)
      0:       return {1'b0, a_data};
      1:       return {1'b0, b_data};
      default: return {2'b0, c_data};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference output register: returns the expected overrun for this commit
  function automatic bit commit_model(input int u, input logic [10:0] fr, input bit rdy);
    if (exp_q[u].size() == 0) begin
      exp_q[u].push_back(fr);
      return 1'b0;
    end
    if (rdy) begin
      void'(exp_q[u].pop_front());
      exp_q[u].push_back(fr);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_head(input int u, input string tag);
    logic [10:0] h;
    h = exp_q[u][0];
    chk({tag, "_valid"}, 32'(valid_o[u]), 32'd1);
    chk({tag, "_data"},  32'(data_of(u)), 32'(h[8:0]));
    chk({tag, "_perr"},  32'(perr_o[u]),  32'(h[10]));
    chk({tag, "_ferr"},  32'(ferr_o[u]),  32'(h[9]));
  endtask

  // one-cycle m_ready pulse; the register must then read empty
  task automatic consume(input int u);
    m_ready[u] = 1'b1;
    tick();
    m_ready[u] = 1'b0;
    if (exp_q[u].size() != 0) void'(exp_q[u].pop_front());
    chk("consume_valid", 32'(valid_o[u]), 32'd0);
  endtask

  // drive one complete frame; inj adds a smpl_ready coincident with start_ok
  // and start_ok pulses mid-frame and on the final stop sample
  task automatic send_frame(input int u, input logic [8:0] data, input bit pflip,
                            input logic [1:0] stops, input int gap_max,
                            input bit inj, input bit rdy_commit, input string tag);
    logic        bits[$];
    logic [8:0]  d;
    logic        ferr;
    logic        pe;
    bit          ovr;
    int          n;
    d = data & 9'((1 << dw_c[u]) - 1);
    for (int i = 0; i < dw_c[u]; i++)
      bits.push_back((msb_c[u] != 0) ? d[dw_c[u]-1-i] : d[i]);
    pe = 1'b0;
    if (pen_c[u] != 0) begin
      bits.push_back((^d) ^ (podd_c[u] != 0) ^ pflip);
      pe = pflip;
    end
    ferr = 1'b0;
    for (int i = 0; i < sb_c[u]; i++) begin
      bits.push_back(stops[i]);
      if (!stops[i]) ferr = 1'b1;
    end

    start_ok[u] = 1'b1;
    if (inj) begin
      smpl_ready[u]  = 1'b1;
      sampled_bit[u] = 1'($urandom_range(0, 1));
    end
    tick();
    start_ok[u]   = 1'b0;
    smpl_ready[u] = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy_o[u]), 32'd1);

    n = bits.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      smpl_ready[u]  = 1'b1;
      sampled_bit[u] = bits[i];
      if (inj && (i == 2 || i == n - 1)) start_ok[u] = 1'b1;
      if (i == n - 1) m_ready[u] = rdy_commit;
      tick();
      smpl_ready[u] = 1'b0;
      start_ok[u]   = 1'b0;
      m_ready[u]    = 1'b0;
    end

    ovr = commit_model(u, {pe, ferr, d}, rdy_commit);
    chk({tag, "_busy_fall"}, 32'(busy_o[u]), 32'd0);
    chk({tag, "_overrun"},   32'(ovr_o[u]),  32'(ovr));
    check_head(u, tag);
    tick();
    chk({tag, "_ovr_clear"}, 32'(ovr_o[u]), 32'd0);
  endtask

  initial begin
    #12;
    for (int u = 0; u < 3; u++) begin
      chk("rst_valid", 32'(valid_o[u]), 32'd0);
      chk("rst_data",  32'(data_of(u)), 32'd0);
      chk("rst_busy",  32'(busy_o[u]),  32'd0);
      chk("rst_ovr",   32'(ovr_o[u]),   32'd0);
    end
    chk("rst_perr", 32'(perr_o), 32'd0);
    chk("rst_ferr", 32'(ferr_o), 32'd0);
    chk("rst_state", 32'({a_st, b_st, c_st}), 32'd0);
    rst = 1'b0;
    tick();

    // 8E1 good frame, then consume
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 2, 1'b0, 1'b0, "a5_good");
    consume(0);
    // 8E1 bad parity
    send_frame(0, 9'h0A5, 1'b1, 2'b11, 2, 1'b0, 1'b0, "a5_perr");
    consume(0);

    // two stop bits, second stop low; spaced then back-to-back
    send_frame(1, 9'h03C, 1'b0, 2'b01, 3, 1'b0, 1'b0, "3c_gap");
    consume(1);
    send_frame(1, 9'h03C, 1'b0, 2'b01, 0, 1'b0, 1'b0, "3c_b2b");
    consume(1);

    // overrun: second frame dropped, then drained in the commit cycle
    send_frame(0, 9'h011, 1'b0, 2'b11, 1, 1'b0, 1'b0, "ovr_first");
    send_frame(0, 9'h022, 1'b0, 2'b11, 1, 1'b0, 1'b0, "ovr_drop");
    consume(0);
    send_frame(0, 9'h011, 1'b0, 2'b11, 1, 1'b0, 1'b0, "ovr_first2");
    send_frame(0, 9'h022, 1'b0, 2'b11, 1, 1'b0, 1'b1, "ovr_drain");
    consume(0);

    // 7-bit MSB-first with ignored start_ok / coincident strobe
    send_frame(2, 9'h065, 1'b0, 2'b11, 2, 1'b1, 1'b0, "c65");
    consume(2);

    // randomized traffic over all three instances
    repeat (60) begin
      int u;
      u = $urandom_range(0, 2);
      send_frame(u, 9'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0),
                 {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 1) == 1) consume(u);
    end

    // reset mid-frame while a frame is held
    send_frame(0, 9'h0C3, 1'b0, 2'b11, 1, 1'b0, 1'b0, "pre_rst");
    start_ok[0] = 1'b1;
    tick();
    start_ok[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smpl_ready[0]  = 1'b1;
      sampled_bit[0] = 1'($urandom_range(0, 1));
      tick();
      smpl_ready[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid_o[0]), 32'd0);
    chk("mid_rst_data",  32'(a_data),     32'd0);
    chk("mid_rst_perr",  32'(perr_o[0]),  32'd0);
    chk("mid_rst_ferr",  32'(ferr_o[0]),  32'd0);
    chk("mid_rst_busy",  32'(busy_o[0]),  32'd0);
    chk("mid_rst_ovr",   32'(ovr_o[0]),   32'd0);
    for (int u = 0; u < 3; u++) exp_q[u].delete();
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_ovr", 32'(ovr_o[0]), 32'd0);
    send_frame(0, 9'h05A, 1'b0, 2'b11, 2, 1'b0, 1'b0, "post_rst_5a");
    consume(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_frame.md
# uart_rx_deser_frame

Parametrised UART receive deserializer/deframer that replaces the fixed 8-bit, externally-counted deserializer in the UART_RX path. It sits after the edge/bit sampler: it takes a validated start-bit pulse and one strobe per sampled bit, and counts bits internally. It assembles data of configurable width and bit order, checks optional parity and one or two stop bits, and presents each frame on a valid/ready output register with parity, framing and overrun flags.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9
- MSB_FIRST, 0, 0 = first data bit received is bit 0; 1 = first data bit received is bit DATA_W-1
- PAR_EN, 1, 1 = a parity bit follows the data bits
- PAR_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PAR_EN=0)
- STOP_BITS, 1, stop bits checked per frame; 1 or 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start_ok  in  1  one-cycle pulse: sampler has validated a start bit
- sampled_bit  in  1  sampled line value, qualified by smpl_ready
- smpl_ready  in  1  one-cycle strobe: sampled_bit is valid for the current bit slot
- m_data  out  DATA_W  received data word
- m_valid  out  1  m_data and flags hold an unconsumed frame
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready
- par_err  out  1  parity mismatch for the frame in m_data; meaningful only with m_valid
- frm_err  out  1  at least one stop bit sampled 0 for the frame in m_data; meaningful only with m_valid
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the output register was full
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states are IDLE, DATA, PARITY and STOP. An internal bit counter sized for max(DATA_W, STOP_BITS) is cleared on every state entry.
- IDLE:
  - start_ok moves the FSM to DATA and clears the shift register, counter, parity accumulator and stop-error flag.
  - smpl_ready is ignored in IDLE.
  - If start_ok and smpl_ready arrive together, start_ok wins and the sample is discarded.
- DATA: each smpl_ready shifts sampled_bit into the shift register.
  - LSB-first: shreg <= {sampled_bit, shreg[DATA_W-1:1]}.
  - MSB-first: shreg <= {shreg[DATA_W-2:0], sampled_bit}.
  - The parity accumulator XORs in each data bit.
  - After the DATA_W-th sample the FSM goes to PARITY if PAR_EN=1, otherwise to STOP.
- PARITY: on smpl_ready the frame parity error is set to (acc ^ sampled_bit) != PAR_ODD, then the FSM goes to STOP. With PAR_EN=0 the parity error is always 0.
- STOP: each smpl_ready with sampled_bit=0 sets the stop-error flag. On the STOP_BITS-th sample the frame commits and the FSM returns to IDLE.
- start_ok is ignored in DATA, PARITY and STOP, including the cycle of the final stop sample.
- Commit:
  - If the output register is empty, or m_valid && m_ready in the same cycle, the register loads shreg, the parity error and the stop error, and m_valid is set.
  - Otherwise the new frame is discarded, the held frame and flags stay unchanged, and overrun pulses for one cycle.
- Output register:
  - m_valid clears on m_valid && m_ready when no commit occurs in the same cycle.
  - m_data, par_err and frm_err stay stable while m_valid && !m_ready.
- Reset, including mid-frame: the FSM goes to IDLE, the partial frame is lost, and no overrun pulse is produced.

## Timing
- Reset values:
  - m_data=0, m_valid=0, par_err=0, frm_err=0, overrun=0, busy=0.
  - Internal: state=IDLE, counter=0, shreg=0.
- busy rises the cycle after start_ok and falls the cycle after the final stop smpl_ready.
- Latency: m_valid, m_data and the flags are registered and update the cycle after the final stop-bit smpl_ready. overrun is registered on the same edge.
- A frame needs exactly DATA_W + PAR_EN + STOP_BITS smpl_ready strobes after start_ok. Strobes may be any number of cycles apart, including back-to-back cycles.
- Throughput: one frame per DATA_W+PAR_EN+STOP_BITS+1 strobe-cycles minimum, with no dead cycle required between the commit and the next start_ok.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Defaults (8E1): start_ok, then bits 1,0,1,0,0,1,0,1 (LSB first), parity 0, stop 1 -> m_valid=1 one cycle after the stop strobe, m_data=0xA5, par_err=0, frm_err=0; m_ready pulse -> m_valid=0 on the next cycle.
- Defaults, same data with parity bit 1 -> m_data=0xA5, par_err=1, frm_err=0.
- STOP_BITS=2: frame 0x3C with second stop bit 0 -> m_data=0x3C, frm_err=1; strobes sent back-to-back on consecutive cycles behave identically.
- Overrun: with m_ready=0, receive 0x11, then 0x22 -> overrun pulses once, m_data stays 0x11. Repeat with m_ready=1 in the commit cycle of 0x22 -> no overrun, m_data=0x22.
- DATA_W=7, MSB_FIRST=1, PAR_EN=0: bits 1,1,0,0,1,0,1 -> m_data=7'h65. A start_ok injected mid-frame and a smpl_ready coincident with start_ok in IDLE are both ignored.
- Assert rst after 4 data bits -> all outputs return to reset values asynchronously; a following clean 0x5A frame decodes correctly with no overrun.
